// File: rtl/mem_access_unit_if.sv
// Request/bus/response signal bundle for mem_access_unit.
// The unit connects through the slave modport; the pipeline/memory side through master.
interface mem_access_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [NB-1:0]     bus_byteen;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  bus_ready, bus_rdata,
    output req_ready, bus_valid, bus_addr, bus_we, bus_byteen, bus_wdata,
    output resp_valid, resp_rdata, resp_err, busy
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output bus_ready, bus_rdata,
    input  req_ready, bus_valid, bus_addr, bus_we, bus_byteen, bus_wdata,
    input  resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access unit: aligns store lanes, splits bus-word crossings into two
// beats, merges and extends load data, and holds busy while an access is in flight.
module mem_access_unit #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  mem_access_if.slave  mif
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, sext_q, cross_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;

  // Request decode, only meaningful while IDLE.
  logic [OFF_W-1:0] req_off;
  logic [4:0]       req_span;
  logic             req_cross, req_size_ok, req_err;

  always_comb begin
    req_off     = mif.req_addr[OFF_W-1:0];
    req_span    = 5'(req_off) + (5'd1 << mif.req_size);
    req_cross   = req_span > 5'(NB);
    req_size_ok = (mif.req_size != 2'd3) || (DATA_W == 64);
    req_err     = !req_size_ok || (req_cross && !MISALIGN_SPLIT);
  end

  // Lane steering: a double-width shift yields both beats at once (low half = beat 0).
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W+2:0]   lane_shift;
  logic [2*NB-1:0]    size_mask, lane_mask;
  logic [2*DATA_W-1:0] wide_wdata, wide_rdata;
  logic [DATA_W-1:0]  rdata1_eff, raw_rdata, ext_rdata;
  logic [ADDR_W-1:0]  base_addr;
  logic               sign_bit;
  int                 nbytes;

  assign off_q      = addr_q[OFF_W-1:0];
  assign lane_shift = {off_q, 3'b000};
  assign base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // NOTE: every always_comb output gets a value on every path (here via default) so no latch is inferred.
  always_comb begin
    case (size_q)
      2'd0:    size_mask = (2*NB)'(8'h01);
      2'd1:    size_mask = (2*NB)'(8'h03);
      2'd2:    size_mask = (2*NB)'(8'h0F);
      default: size_mask = (2*NB)'(8'hFF);
    endcase
  end

  assign lane_mask  = size_mask << off_q;
  assign wide_wdata = {{DATA_W{1'b0}}, wdata_q} << lane_shift;
  assign rdata1_eff = cross_q ? rdata1_q : {DATA_W{1'b0}};
  assign wide_rdata = {rdata1_eff, rdata0_q} >> lane_shift;
  assign raw_rdata  = wide_rdata[DATA_W-1:0];

  always_comb begin
    nbytes   = 1 << size_q;
    sign_bit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == nbytes - 1) sign_bit = raw_rdata[8*i+7];
    end
    ext_rdata = raw_rdata;
    for (int i = 0; i < NB; i++) begin
      if (i >= nbytes) ext_rdata[8*i +: 8] = {8{sext_q & sign_bit}};
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: these are plain flops, not a memory array, so all of them are cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      sext_q   <= 1'b0;
      cross_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (mif.req_valid) begin
          we_q     <= mif.req_we;
          sext_q   <= mif.req_sext;
          size_q   <= mif.req_size;
          addr_q   <= mif.req_addr;
          wdata_q  <= mif.req_wdata;
          cross_q  <= req_cross;
          err_q    <= req_err;
          rdata0_q <= '0;
          rdata1_q <= '0;
        end
        BEAT0:   if (mif.bus_ready) rdata0_q <= mif.bus_rdata;
        BEAT1:   if (mif.bus_ready) rdata1_q <= mif.bus_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    mif.req_ready  = 1'b0;
    mif.bus_valid  = 1'b0;
    mif.bus_addr   = '0;
    mif.bus_we     = 1'b0;
    mif.bus_byteen = '0;
    mif.bus_wdata  = '0;
    mif.resp_valid = 1'b0;
    mif.resp_err   = 1'b0;
    mif.resp_rdata = '0;
    case (state_q)
      IDLE: begin
        mif.req_ready = 1'b1;
        if (mif.req_valid) state_d = req_err ? RESP : BEAT0;
      end
      BEAT0: begin
        mif.bus_valid  = 1'b1;
        mif.bus_addr   = base_addr;
        mif.bus_we     = we_q;
        mif.bus_byteen = we_q ? lane_mask[NB-1:0] : '0;
        mif.bus_wdata  = wide_wdata[DATA_W-1:0];
        if (mif.bus_ready) state_d = cross_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mif.bus_valid  = 1'b1;
        mif.bus_addr   = base_addr + ADDR_W'(NB);
        mif.bus_we     = we_q;
        mif.bus_byteen = we_q ? lane_mask[2*NB-1:NB] : '0;
        mif.bus_wdata  = wide_wdata[2*DATA_W-1:DATA_W];
        if (mif.bus_ready) state_d = RESP;
      end
      RESP: begin
        mif.resp_valid = 1'b1;
        mif.resp_err   = err_q;
        mif.resp_rdata = (err_q || we_q) ? '0 : ext_rdata;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mif.busy = (state_q != IDLE);
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: dut_a splits boundary crossings, dut_b reports them as errors.
// Drivers push expected beats/responses; a negedge monitor pops and compares.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_access_if #(.DATA_W(32), .ADDR_W(32)) if_a ();
  mem_access_if #(.DATA_W(32), .ADDR_W(32)) if_b ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .mif(if_a));
  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .mif(if_b));

  // Word-addressed memory image returning read data for dut_a.
  logic [31:0] mem [256];
  assign if_a.bus_rdata = mem[if_a.bus_addr[9:2]];
  assign if_b.bus_rdata = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } resp_t;

  beat_t exp_beat_a[$];
  resp_t exp_resp_a[$];
  resp_t exp_resp_b[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b_bus_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic beat_t bt(input logic [31:0] addr, input logic we,
                               input logic [3:0] be, input logic [31:0] wd);
    beat_t b;
    b.addr = addr; b.we = we; b.byteen = be; b.wdata = wd;
    return b;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
  task automatic issue(input bit on_b, input logic we, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                       input int nbeats, input beat_t b0, input beat_t b1,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    int    waited = 0;
    logic  rr;
    resp_t r;
    rr = on_b ? if_b.req_ready : if_a.req_ready;
    while (!rr && waited < 50) begin
      @(posedge clk); #1;
      waited++;
      rr = on_b ? if_b.req_ready : if_a.req_ready;
    end
    check("req_ready_before_issue", 32'(rr), 32'd1);
    if (!rr) return;
    if (!on_b && nbeats > 0) exp_beat_a.push_back(b0);
    if (!on_b && nbeats > 1) exp_beat_a.push_back(b1);
    r.rdata = exp_rdata; r.err = exp_err; r.acc = cyc; r.lat = lat;
    if (on_b) begin
      exp_resp_b.push_back(r);
      if_b.req_we = we; if_b.req_size = size; if_b.req_sext = sext;
      if_b.req_addr = addr; if_b.req_wdata = wdata; if_b.req_valid = 1'b1;
    end else begin
      exp_resp_a.push_back(r);
      if_a.req_we = we; if_a.req_size = size; if_a.req_sext = sext;
      if_a.req_addr = addr; if_a.req_wdata = wdata; if_a.req_valid = 1'b1;
    end
    @(posedge clk); #1;
    if_a.req_valid = 1'b0;
    if_b.req_valid = 1'b0;
  endtask

  task automatic wait_idle_a();
    int waited = 0;
    while (!if_a.req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("a_idle_wait", 32'(if_a.req_ready), 32'd1);
  endtask

  // Monitor: compares beats (including every stalled cycle) and responses against the queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (if_a.bus_valid) begin
        if (exp_beat_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_beat: unexpected beat addr=%h", if_a.bus_addr);
        end else begin
          beat_t e;
          e = exp_beat_a[0];
          check("a_bus_addr", if_a.bus_addr, e.addr);
          check("a_bus_we", 32'(if_a.bus_we), 32'(e.we));
          check("a_bus_byteen", 32'(if_a.bus_byteen), 32'(e.byteen));
          if (e.we)
            check("a_bus_wdata", if_a.bus_wdata & lanes(e.byteen), e.wdata & lanes(e.byteen));
          if (if_a.bus_ready) void'(exp_beat_a.pop_front());
        end
      end
      if (if_a.resp_valid) begin
        if (exp_resp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_resp: unexpected response rdata=%h", if_a.resp_rdata);
        end else begin
          resp_t e;
          e = exp_resp_a.pop_front();
          check("a_resp_rdata", if_a.resp_rdata, e.rdata);
          check("a_resp_err", 32'(if_a.resp_err), 32'(e.err));
          check("a_resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (if_b.bus_valid) b_bus_cnt++;
      if (if_b.resp_valid) begin
        if (exp_resp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_resp: unexpected response err=%0b", if_b.resp_err);
        end else begin
          resp_t e;
          e = exp_resp_b.pop_front();
          check("b_resp_rdata", if_b.resp_rdata, e.rdata);
          check("b_resp_err", 32'(if_b.resp_err), 32'(e.err));
          check("b_resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  beat_t nob;

  initial begin
    nob = bt(32'h0, 1'b0, 4'h0, 32'h0);
    foreach (mem[i]) mem[i] = 32'h0;
    reset_n = 1'b0;
    if_a.req_valid = 1'b0; if_a.req_we = 1'b0; if_a.req_size = 2'd0; if_a.req_sext = 1'b0;
    if_a.req_addr = 32'h0; if_a.req_wdata = 32'h0; if_a.bus_ready = 1'b1;
    if_b.req_valid = 1'b0; if_b.req_we = 1'b0; if_b.req_size = 2'd0; if_b.req_sext = 1'b0;
    if_b.req_addr = 32'h0; if_b.req_wdata = 32'h0; if_b.bus_ready = 1'b1;

    repeat (2) @(posedge clk); #1;
    check("rst_req_ready", 32'(if_a.req_ready), 32'd1);
    check("rst_bus_valid", 32'(if_a.bus_valid), 32'd0);
    check("rst_resp_valid", 32'(if_a.resp_valid), 32'd0);
    check("rst_busy", 32'(if_a.busy), 32'd0);
    check("rst_resp_rdata", if_a.resp_rdata, 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // lb sext at 0x103: byte 3 of 0x80FF0000 is 0x80 -> 0xFFFFFF80
    mem[8'h40] = 32'h80FF_0000;
    issue(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, bt(32'h100, 1'b0, 4'b0000, 32'h0), nob,
          32'hFFFF_FF80, 1'b0, 2);
    // lbu at 0x103 -> 0x00000080
    issue(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, bt(32'h100, 1'b0, 4'b0000, 32'h0), nob,
          32'h0000_0080, 1'b0, 2);
    // sh at 0x102: lanes 2,3
    issue(0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 1, bt(32'h100, 1'b1, 4'b1100, 32'hBEEF_0000), nob,
          32'h0, 1'b0, 2);
    // sb at 0x101 with junk upper store bits: only lane 1 (0xA5) is enabled
    issue(0, 1'b1, 2'd0, 1'b0, 32'h101, 32'hFFFF_FFA5, 1, bt(32'h100, 1'b1, 4'b0010, 32'h0000_A500), nob,
          32'h0, 1'b0, 2);
    // sw at 0x0FE splits across 0x0FC / 0x100
    issue(0, 1'b1, 2'd2, 1'b0, 32'h0FE, 32'h1122_3344, 2,
          bt(32'h0FC, 1'b1, 4'b1100, 32'h3344_0000), bt(32'h100, 1'b1, 4'b0011, 32'h0000_1122),
          32'h0, 1'b0, 3);
    wait_idle_a();

    // Loads spanning 0x0FC (bytes DD,CC,BB,AA) and 0x100 (bytes 44,33,22,11)
    mem[8'h3F] = 32'hAABB_CCDD;
    mem[8'h40] = 32'h1122_3344;
    // lw at 0x0FF: bytes AA,44,33,22 -> 0x223344AA
    issue(0, 1'b0, 2'd2, 1'b0, 32'h0FF, 32'h0, 2,
          bt(32'h0FC, 1'b0, 4'b0000, 32'h0), bt(32'h100, 1'b0, 4'b0000, 32'h0),
          32'h2233_44AA, 1'b0, 3);
    // lh sext at 0x0FE: bytes BB,AA -> 0xFFFFAABB
    issue(0, 1'b0, 2'd1, 1'b1, 32'h0FE, 32'h0, 1, bt(32'h0FC, 1'b0, 4'b0000, 32'h0), nob,
          32'hFFFF_AABB, 1'b0, 2);
    // lhu at 0x0FF (split): bytes AA,44 -> 0x000044AA
    issue(0, 1'b0, 2'd1, 1'b0, 32'h0FF, 32'h0, 2,
          bt(32'h0FC, 1'b0, 4'b0000, 32'h0), bt(32'h100, 1'b0, 4'b0000, 32'h0),
          32'h0000_44AA, 1'b0, 3);
    // lw aligned at 0x100
    issue(0, 1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 1, bt(32'h100, 1'b0, 4'b0000, 32'h0), nob,
          32'h1122_3344, 1'b0, 2);
    // dword size is illegal at DATA_W=32: error after one cycle, no beat
    issue(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, nob, nob, 32'h0, 1'b1, 1);
    // sw at 0xFFFFFFFE: second beat address wraps to 0
    issue(0, 1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_1234, 2,
          bt(32'hFFFF_FFFC, 1'b1, 4'b1100, 32'h1234_0000), bt(32'h0000_0000, 1'b1, 4'b0011, 32'h0000_CAFE),
          32'h0, 1'b0, 3);

    // No-split unit: crossing and illegal size are errors with no bus traffic
    issue(1, 1'b0, 2'd1, 1'b0, 32'h003, 32'h0, 0, nob, nob, 32'h0, 1'b1, 1);
    issue(1, 1'b1, 2'd2, 1'b0, 32'h002, 32'h1234_5678, 0, nob, nob, 32'h0, 1'b1, 1);
    issue(1, 1'b0, 2'd3, 1'b1, 32'h000, 32'h0, 0, nob, nob, 32'h0, 1'b1, 1);

    // Two wait states on an aligned load stretch latency to 4
    wait_idle_a();
    if_a.bus_ready = 1'b0;
    issue(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1, bt(32'h100, 1'b0, 4'b0000, 32'h0), nob,
          32'h1122_3344, 1'b0, 4);
    repeat (2) @(posedge clk); #1;
    if_a.bus_ready = 1'b1;

    // Stall a split store in beat 0 for 5 cycles, then reset mid-access
    wait_idle_a();
    repeat (2) @(posedge clk); #1;
    if_a.bus_ready = 1'b0;
    issue(0, 1'b1, 2'd2, 1'b0, 32'h0FE, 32'h1122_3344, 2,
          bt(32'h0FC, 1'b1, 4'b1100, 32'h3344_0000), bt(32'h100, 1'b1, 4'b0011, 32'h0000_1122),
          32'h0, 1'b0, 3);
    repeat (5) @(posedge clk); #1;
    check("stall_bus_valid", 32'(if_a.bus_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_bus_valid", 32'(if_a.bus_valid), 32'd0);
    check("midrst_resp_valid", 32'(if_a.resp_valid), 32'd0);
    check("midrst_req_ready", 32'(if_a.req_ready), 32'd1);
    check("midrst_busy", 32'(if_a.busy), 32'd0);
    check("midrst_byteen", 32'(if_a.bus_byteen), 32'd0);
    exp_beat_a.delete();
    exp_resp_a.delete();
    #1 reset_n = 1'b1;
    if_a.bus_ready = 1'b1;

    // Unit recovers and serves a fresh load after the abandoned access
    issue(0, 1'b0, 2'd0, 1'b1, 32'h0FC, 32'h0, 1, bt(32'h0FC, 1'b0, 4'b0000, 32'h0), nob,
          32'hFFFF_FFDD, 1'b0, 2);
    wait_idle_a();
    repeat (3) @(posedge clk); #1;

    check("a_beats_left", 32'(exp_beat_a.size()), 32'd0);
    check("a_resps_left", 32'(exp_resp_a.size()), 32'd0);
    check("b_resps_left", 32'(exp_resp_b.size()), 32'd0);
    check("b_bus_valid_cycles", 32'(b_bus_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
